// File: rtl/tile_row_fetch.sv
// Row fetcher for the 80x60 tile-map SRAM: fills a ping-pong line buffer and arbitrates the SRAM port.
// Optional `TILE_FETCH_STALL_STATS_EN adds o_stall_cnt (write-granted cycles during FETCH).
module tile_row_fetch #(
    parameter int unsigned COLS         = 80,
    parameter int unsigned ROWS         = 60,
    parameter int unsigned ADDR_WIDTH   = 13,
    parameter int unsigned DATA_WIDTH   = 3,
    parameter int unsigned MAX_WR_BURST = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_fetch,
    input  logic [5:0]            i_row,
    output logic                  o_busy,
    output logic                  o_fetch_done,
    input  logic                  i_swap,
    input  logic [6:0]            i_col,
    output logic [DATA_WIDTH-1:0] o_tile,
    input  logic                  i_wr_req,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_ack,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic                  o_ram_write,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    input  logic [DATA_WIDTH-1:0] i_ram_data
`ifdef TILE_FETCH_STALL_STATS_EN
    ,
    output logic [15:0]           o_stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    localparam int unsigned BURST_W = $clog2(MAX_WR_BURST + 1);
    localparam logic [5:0] ROW_LIMIT = 6'(ROWS);
    localparam logic [6:0] COL_LIMIT = 7'(COLS);
    localparam logic [6:0] LAST_COL  = 7'(COLS - 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_WR_BURST);

    state_t                 state_q, state_d;
    logic [6:0]             col_q, col_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic                   target_q, target_d;
    logic                   front_q, front_d;
    logic [BURST_W-1:0]     burst_q, burst_d;
    logic                   rd_vld_q, rd_vld_d;
    logic [6:0]             rd_col_q, rd_col_d;
    logic                   done_q, done_d;
    logic [DATA_WIDTH-1:0]  tile_q;
    logic [DATA_WIDTH-1:0]  buf_q [2][COLS];
`ifdef TILE_FETCH_STALL_STATS_EN
    logic [15:0]            stall_q, stall_d;
`endif

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        base_d      = base_q;
        target_d    = target_q;
        // Swap lands first so a same-cycle fetch targets the new back buffer.
        front_d     = front_q ^ i_swap;
        burst_d     = burst_q;
        rd_vld_d    = 1'b0;
        rd_col_d    = col_q;
        done_d      = 1'b0;
        o_ram_addr  = '0;
        o_ram_write = 1'b0;
        o_wr_ack    = 1'b0;
`ifdef TILE_FETCH_STALL_STATS_EN
        stall_d     = stall_q;
`endif
        unique case (state_q)
            FETCH: begin
                if (i_wr_req && (burst_q < BURST_MAX)) begin
                    o_ram_write = 1'b1;
                    o_wr_ack    = 1'b1;
                    o_ram_addr  = i_wr_addr;
                    burst_d     = burst_q + BURST_W'(1);
`ifdef TILE_FETCH_STALL_STATS_EN
                    if (stall_q != '1) stall_d = stall_q + 16'd1;
`endif
                end else begin
                    o_ram_addr = base_q + ADDR_WIDTH'(col_q);
                    burst_d    = '0;
                    col_d      = col_q + 7'd1;
                    rd_vld_d   = 1'b1;
                    rd_col_d   = col_q;
                    if (col_q == LAST_COL) state_d = DRAIN;
                end
            end
            default: begin
                o_ram_write = i_wr_req;
                o_wr_ack    = i_wr_req;
                if (i_wr_req) o_ram_addr = i_wr_addr;
                if (state_q == DRAIN) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (i_fetch && (i_row < ROW_LIMIT)) begin
                    state_d  = FETCH;
                    base_d   = ADDR_WIDTH'({i_row, 6'b0}) + ADDR_WIDTH'({i_row, 4'b0});
                    col_d    = '0;
                    burst_d  = '0;
                    target_d = ~front_d;
`ifdef TILE_FETCH_STALL_STATS_EN
                    stall_d  = '0;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            col_q    <= '0;
            base_q   <= '0;
            target_q <= 1'b0;
            front_q  <= 1'b0;
            burst_q  <= '0;
            rd_vld_q <= 1'b0;
            rd_col_q <= '0;
            done_q   <= 1'b0;
            tile_q   <= '0;
`ifdef TILE_FETCH_STALL_STATS_EN
            stall_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            base_q   <= base_d;
            target_q <= target_d;
            front_q  <= front_d;
            burst_q  <= burst_d;
            rd_vld_q <= rd_vld_d;
            rd_col_q <= rd_col_d;
            done_q   <= done_d;
            tile_q   <= (i_col < COL_LIMIT) ? buf_q[front_q][i_col] : '0;
`ifdef TILE_FETCH_STALL_STATS_EN
            stall_q  <= stall_d;
`endif
        end
    end

    // Read data lands one cycle after issue; reset drops whatever is in flight.
    always_ff @(posedge i_clk) begin
        if (rd_vld_q && !i_rst) buf_q[target_q][rd_col_q] <= i_ram_data;
    end

    assign o_busy       = (state_q != IDLE);
    assign o_fetch_done = done_q;
    assign o_tile       = tile_q;
    assign o_ram_data   = i_wr_data;
`ifdef TILE_FETCH_STALL_STATS_EN
    assign o_stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_tile_row_fetch.sv
// Self-checking bench for tile_row_fetch: SRAM model with tile(r,c)=(r+c)%6 plus a reference map.
module tb_tile_row_fetch;

    logic        clk = 1'b0;
    logic        i_rst, i_fetch, i_swap, i_wr_req;
    logic [5:0]  i_row;
    logic [6:0]  i_col;
    logic [12:0] i_wr_addr;
    logic [2:0]  i_wr_data;
    logic        o_busy, o_fetch_done, o_wr_ack, o_ram_write;
    logic [2:0]  o_tile, o_ram_data, ram_q;
    logic [12:0] o_ram_addr;
`ifdef TILE_FETCH_STALL_STATS_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    tile_row_fetch #(.COLS(80), .ROWS(60), .ADDR_WIDTH(13), .DATA_WIDTH(3), .MAX_WR_BURST(4)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_fetch(i_fetch), .i_row(i_row),
        .o_busy(o_busy), .o_fetch_done(o_fetch_done), .i_swap(i_swap), .i_col(i_col),
        .o_tile(o_tile), .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .o_wr_ack(o_wr_ack), .o_ram_addr(o_ram_addr), .o_ram_write(o_ram_write),
        .o_ram_data(o_ram_data), .i_ram_data(ram_q)
`ifdef TILE_FETCH_STALL_STATS_EN
        , .o_stall_cnt(stall_cnt)
`endif
    );

    // SRAM model: registered read, output holds across write cycles.
    logic       mem_init;
    logic [2:0] mem [4800];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4800; i++) mem[i] <= 3'((i / 80 + i % 80) % 6);
        end else if (o_ram_write) begin
            if (o_ram_addr < 13'd4800) mem[o_ram_addr] <= o_ram_data;
        end else begin
            ram_q <= (o_ram_addr < 13'd4800) ? mem[o_ram_addr] : 3'd0;
        end
    end

    typedef struct {
        logic        req;
        logic [12:0] addr;
        logic [2:0]  data;
        logic        exp_ack;
        logic        exp_write;
        logic [12:0] exp_addr;
    } wr_vec_t;

    typedef struct {
        logic [6:0] col;
        logic [2:0] exp_tile;
    } col_vec_t;

    wr_vec_t    wr_tab [6];
    col_vec_t   col_tab [8];
    logic [2:0] ref_mem [4800];
    logic [2:0] exp_row [80];
    logic [2:0] row21 [80];
    logic [2:0] row30 [80];
    int         nvec = 0;
    int         nerr = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic snap_row(input int r);
        for (int c = 0; c < 80; c++) exp_row[c] = ref_mem[r * 80 + c];
    endtask

    task automatic start_fetch(input int row, input logic sw);
        i_row   = 6'(row);
        i_fetch = 1'b1;
        i_swap  = sw;
        tick();
        i_fetch = 1'b0;
        i_swap  = 1'b0;
    endtask

    task automatic wait_done(input int k0, input int exp, input string nm);
        int k;
        k = k0;
        while (o_fetch_done !== 1'b1 && k < exp + 40) begin
            tick();
            k++;
        end
        check(nm, k, exp);
        tick();
        check({nm, "_pulse_end"}, o_fetch_done, 0);
        check({nm, "_idle"}, o_busy, 0);
    endtask

    task automatic do_swap();
        i_swap = 1'b1;
        tick();
        i_swap = 1'b0;
    endtask

    task automatic check_row(input string nm);
        for (int c = 0; c < 80; c++) begin
            i_col = 7'(c);
            tick();
            check($sformatf("%s[%0d]", nm, c), o_tile, exp_row[c]);
        end
    endtask

    task automatic write_idle(input int addr, input int data);
        i_wr_req  = 1'b1;
        i_wr_addr = 13'(addr);
        i_wr_data = 3'(data);
        #1;
        check("idle_write_ack", o_wr_ack, 1);
        tick();
        i_wr_req = 1'b0;
        ref_mem[addr] = 3'(data);
    endtask

    task automatic bg_writes(input int n, input int avoid);
        int r, addr, d, g;
        for (int i = 0; i < n; i++) begin
            do r = $urandom_range(0, 59); while (r == avoid);
            addr = r * 80 + $urandom_range(0, 79);
            d    = $urandom_range(0, 7);
            i_wr_req  = 1'b1;
            i_wr_addr = 13'(addr);
            i_wr_data = 3'(d);
            g = 0;
            #1;
            while (o_wr_ack !== 1'b1 && g < 20) begin
                tick();
                #1;
                g++;
            end
            check("bg_write_grant", o_wr_ack, 1);
            ref_mem[addr] = 3'(d);
            tick();
        end
        i_wr_req = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int perr, b, d, a, pulses, first, r, n;
        logic sw;

        wr_tab[0] = '{1'b1, 13'd4000, 3'd1, 1'b1, 1'b1, 13'd4000};
        wr_tab[1] = '{1'b0, 13'd4000, 3'd2, 1'b0, 1'b0, 13'd0};
        wr_tab[2] = '{1'b1, 13'd0,    3'd3, 1'b1, 1'b1, 13'd0};
        wr_tab[3] = '{1'b1, 13'd4799, 3'd4, 1'b1, 1'b1, 13'd4799};
        wr_tab[4] = '{1'b0, 13'd1234, 3'd5, 1'b0, 1'b0, 13'd0};
        wr_tab[5] = '{1'b1, 13'd1234, 3'd2, 1'b1, 1'b1, 13'd1234};
        col_tab[0] = '{7'd0,   3'd1};
        col_tab[1] = '{7'd1,   3'd2};
        col_tab[2] = '{7'd5,   3'd0};
        col_tab[3] = '{7'd50,  3'd3};
        col_tab[4] = '{7'd79,  3'd2};
        col_tab[5] = '{7'd80,  3'd0};
        col_tab[6] = '{7'd100, 3'd0};
        col_tab[7] = '{7'd127, 3'd0};
        for (int rr = 0; rr < 60; rr++)
            for (int c = 0; c < 80; c++) ref_mem[rr * 80 + c] = 3'((rr + c) % 6);

        i_rst = 1'b1; mem_init = 1'b1; i_fetch = 1'b0; i_swap = 1'b0; i_wr_req = 1'b0;
        i_row = '0; i_col = '0; i_wr_addr = '0; i_wr_data = '0;
        repeat (3) tick();
        i_rst = 1'b0; mem_init = 1'b0;
        check("reset_busy", o_busy, 0);
        check("reset_done", o_fetch_done, 0);
        check("reset_tile", o_tile, 0);
`ifdef TILE_FETCH_STALL_STATS_EN
        check("reset_stall", stall_cnt, 0);
`endif

        // IDLE pass-through arbitration vectors
        foreach (wr_tab[i]) begin
            i_wr_req  = wr_tab[i].req;
            i_wr_addr = wr_tab[i].addr;
            i_wr_data = wr_tab[i].data;
            #1;
            check($sformatf("idle_ack[%0d]", i), o_wr_ack, wr_tab[i].exp_ack);
            check($sformatf("idle_write[%0d]", i), o_ram_write, wr_tab[i].exp_write);
            check($sformatf("idle_addr[%0d]", i), o_ram_addr, wr_tab[i].exp_addr);
            check($sformatf("idle_data[%0d]", i), o_ram_data, wr_tab[i].data);
            tick();
            if (wr_tab[i].req) ref_mem[wr_tab[i].addr] = wr_tab[i].data;
        end
        i_wr_req = 1'b0;

        // Plain fetch of row 25
        snap_row(25);
        start_fetch(25, 1'b0);
        check("row25_busy_rise", o_busy, 1);
        wait_done(1, 82, "row25_done_cycle");
        do_swap();
        check_row("row25");
        foreach (col_tab[i]) begin
            i_col = col_tab[i].col;
            tick();
            check($sformatf("row25_col%0d", col_tab[i].col), o_tile, col_tab[i].exp_tile);
        end

        // Write request held for the whole fetch of row 3
        snap_row(3);
        i_wr_req = 1'b1; i_wr_addr = 13'd4790; i_wr_data = 3'd6;
        start_fetch(3, 1'b0);
        perr = 0;
        for (int k = 1; k <= 400; k++) begin
            #1;
            if (o_ram_write !== ((k % 5) != 0)) perr++;
            if (o_fetch_done !== 1'b0) perr++;
            tick();
        end
        check("held_write_pattern_errors", perr, 0);
        wait_done(401, 402, "row3_done_cycle");
        i_wr_req = 1'b0;
        ref_mem[4790] = 3'd6;
`ifdef TILE_FETCH_STALL_STATS_EN
        check("row3_stall_cnt", stall_cnt, 320);
`endif
        do_swap();
        check_row("row3");

        // Writes into the row being fetched, before and after column 50 is read
        snap_row(10);
        start_fetch(10, 1'b0);
        repeat (9) tick();
        i_wr_req = 1'b1; i_wr_addr = 13'd850; i_wr_data = 3'd5;
        #1;
        check("row10_early_write_ack", o_wr_ack, 1);
        tick();
        i_wr_req = 1'b0;
        repeat (59) tick();
        i_wr_req = 1'b1; i_wr_addr = 13'd850; i_wr_data = 3'd4;
        #1;
        check("row10_late_write_ack", o_wr_ack, 1);
        tick();
        i_wr_req = 1'b0;
        wait_done(71, 84, "row10_done_cycle");
`ifdef TILE_FETCH_STALL_STATS_EN
        check("row10_stall_cnt", stall_cnt, 2);
`endif
        exp_row[50] = 3'd5;
        ref_mem[850] = 3'd4;
        do_swap();
        check_row("row10");
        snap_row(10);
        start_fetch(10, 1'b0);
        wait_done(1, 82, "row10_refetch_done");
        do_swap();
        check_row("row10_refetch");

        // Out-of-range row, then a second trigger while busy
        start_fetch(60, 1'b0);
        b = 0; d = 0; a = 0;
        repeat (90) begin
            #1;
            if (o_busy !== 1'b0) b++;
            if (o_fetch_done !== 1'b0) d++;
            if (o_ram_addr !== 13'd0 || o_ram_write !== 1'b0) a++;
            tick();
        end
        check("row60_busy_cycles", b, 0);
        check("row60_done_pulses", d, 0);
        check("row60_ram_accesses", a, 0);
        snap_row(7);
        start_fetch(7, 1'b0);
        repeat (4) tick();
        i_row = 6'd8; i_fetch = 1'b1;
        tick();
        i_fetch = 1'b0;
        pulses = 0; first = 0;
        for (int k = 6; k <= 200; k++) begin
            if (o_fetch_done === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
            tick();
        end
        check("busy_refetch_pulses", pulses, 1);
        check("busy_refetch_done_cycle", first, 82);
        do_swap();
        check_row("row7");

        // Reset in the middle of a fetch
        start_fetch(20, 1'b0);
        i_col = 7'd1;
        repeat (40) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("midreset_busy", o_busy, 0);
        check("midreset_tile", o_tile, 0);
        check("midreset_done", o_fetch_done, 0);
`ifdef TILE_FETCH_STALL_STATS_EN
        check("midreset_stall", stall_cnt, 0);
`endif
        d = 0;
        repeat (100) begin
            if (o_fetch_done !== 1'b0) d++;
            tick();
        end
        check("midreset_done_pulses", d, 0);
        snap_row(21);
        row21 = exp_row;
        start_fetch(21, 1'b0);
        wait_done(1, 82, "post_reset_done_cycle");
        do_swap();
        check_row("row21");

        // Swap mid-fetch: display flips at once, fetch keeps its latched target
        snap_row(30);
        row30 = exp_row;
        start_fetch(30, 1'b0);
        i_col = 7'd5;
        repeat (18) tick();
        check("preswap_tile", o_tile, 32'(row21[5]));
        i_swap = 1'b1;
        tick();
        i_swap = 1'b0;
        tick();
        check("midswap_tile", o_tile, 32'(row30[5]));
        wait_done(21, 82, "midswap_done_cycle");
        check_row("midswap_row30");
        do_swap();
        exp_row = row21;
        check_row("midswap_row21");

        // Fetch and swap in the same IDLE cycle
        start_fetch(40, 1'b1);
        wait_done(1, 82, "fetchswap_done_cycle");
        exp_row = row30;
        check_row("fetchswap_front");
        snap_row(40);
        do_swap();
        check_row("fetchswap_row40");

        // Randomised fetches with background writes to other rows
        for (int it = 0; it < 6; it++) begin
            write_idle($urandom_range(0, 4799), $urandom_range(0, 7));
            write_idle($urandom_range(0, 4799), $urandom_range(0, 7));
            r  = $urandom_range(0, 59);
            n  = $urandom_range(0, 12);
            sw = 1'($urandom_range(0, 1));
            snap_row(r);
            start_fetch(r, sw);
            fork
                bg_writes(n, r);
                wait_done(1, 82 + n, $sformatf("rand%0d_done_cycle", it));
            join
`ifdef TILE_FETCH_STALL_STATS_EN
            check($sformatf("rand%0d_stall_cnt", it), stall_cnt, n);
`endif
            do_swap();
            check_row($sformatf("rand%0d_row%0d", it, r));
            i_col = 7'($urandom_range(80, 127));
            tick();
            check($sformatf("rand%0d_col_oob", it), o_tile, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
